// File: rtl/async_fifo_wr_status_if.sv
// Write-side status bundle of an async FIFO: pointers and request in,
// full, accept, level and error flags out.
interface async_fifo_wr_status_if #(
  parameter int unsigned COUNTER_BITS = 4
);

  logic [COUNTER_BITS-1:0] rd_gcode_ptr_async;
  logic [COUNTER_BITS-1:0] wr_gcode_ptr;
  logic                    wr_req;
  logic                    wr_incr;
  logic                    wr_full;
  logic                    wr_almost_full;
  logic [COUNTER_BITS-1:0] wr_level;
  logic                    wr_overflow;

  // Status block side
  modport slave (
    input  rd_gcode_ptr_async,
    input  wr_gcode_ptr,
    input  wr_req,
    output wr_incr,
    output wr_full,
    output wr_almost_full,
    output wr_level,
    output wr_overflow
  );

  // Producer / pointer-counter side
  modport master (
    output rd_gcode_ptr_async,
    output wr_gcode_ptr,
    output wr_req,
    input  wr_incr,
    input  wr_full,
    input  wr_almost_full,
    input  wr_level,
    input  wr_overflow
  );

endinterface

// File: rtl/async_fifo_wr_status.sv
// Write-domain status for an async FIFO: synchronizes the read gray pointer,
// derives full/accept combinationally and level/almost-full/overflow registered.
module async_fifo_wr_status #(
  parameter int unsigned COUNTER_BITS = 4,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned AFULL_THRESH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  async_fifo_wr_status_if.slave bus
);

  localparam int unsigned DEPTH = 1 << (COUNTER_BITS - 1);
  localparam int unsigned MSB   = COUNTER_BITS - 1;
  // Inverting the two MSBs of a gray pointer yields the pointer one full lap ahead
  localparam logic [COUNTER_BITS-1:0] FULL_MASK = {2'b11, {(COUNTER_BITS-2){1'b0}}};

  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("async_fifo_wr_status: SYNC_STAGES must be at least 2");
  end
  if (COUNTER_BITS < 3) begin : g_chk_bits
    $error("async_fifo_wr_status: COUNTER_BITS must be at least 3");
  end
  if ((AFULL_THRESH < 1) || (AFULL_THRESH > DEPTH)) begin : g_chk_afull
    $error("async_fifo_wr_status: AFULL_THRESH must be within 1..DEPTH");
  end

  function automatic logic [COUNTER_BITS-1:0] gray2bin(input logic [COUNTER_BITS-1:0] g);
    logic [COUNTER_BITS-1:0] b;
    b[MSB] = g[MSB];
    for (int i = int'(MSB) - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [SYNC_STAGES-1:0][COUNTER_BITS-1:0] r_rd_sync;
  logic [COUNTER_BITS-1:0]                  r_level;
  logic                                     r_almost_full;
  logic                                     r_overflow;

  logic [COUNTER_BITS-1:0] w_rd_sync;
  logic [COUNTER_BITS-1:0] w_rd_bin;
  logic [COUNTER_BITS-1:0] w_wr_bin;
  logic [COUNTER_BITS-1:0] w_occupancy;
  logic                    w_full;
  logic                    w_incr;

  // Only entry point for the foreign-domain read pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_sync <= '0;
    end else begin
      r_rd_sync <= {r_rd_sync[SYNC_STAGES-2:0], bus.rd_gcode_ptr_async};
    end
  end

  assign w_rd_sync   = r_rd_sync[SYNC_STAGES-1];
  assign w_rd_bin    = gray2bin(w_rd_sync);
  assign w_wr_bin    = gray2bin(bus.wr_gcode_ptr);
  assign w_occupancy = w_wr_bin - w_rd_bin;

  // Lagging synchronized read pointer can only make full pessimistic
  assign w_full = (bus.wr_gcode_ptr == (w_rd_sync ^ FULL_MASK));
  assign w_incr = bus.wr_req & ~w_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_level       <= '0;
      r_almost_full <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_level       <= w_occupancy;
      r_almost_full <= (w_occupancy >= COUNTER_BITS'(AFULL_THRESH));
      if (bus.wr_req && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign bus.wr_full        = w_full;
  assign bus.wr_incr        = w_incr;
  assign bus.wr_level       = r_level;
  assign bus.wr_almost_full = r_almost_full;
  assign bus.wr_overflow    = r_overflow;

endmodule

// File: tb/tb_async_fifo_wr_status.sv
// Directed bench for async_fifo_wr_status with hand-computed expectations.
module tb_async_fifo_wr_status;

  localparam int unsigned CB = 4;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  async_fifo_wr_status_if #(.COUNTER_BITS(CB)) bus ();

  async_fifo_wr_status #(
    .COUNTER_BITS(CB),
    .SYNC_STAGES (2),
    .AFULL_THRESH(6)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset                  = 1'b1;
    bus.rd_gcode_ptr_async = '0;
    bus.wr_gcode_ptr       = '0;
    bus.wr_req             = 1'b1;
    #3;
    // Reset with both pointers zero
    check("rst_full",     32'(bus.wr_full), 32'd0);
    check("rst_incr",     32'(bus.wr_incr), 32'd1);
    check("rst_level",    32'(bus.wr_level), 32'd0);
    check("rst_overflow", 32'(bus.wr_overflow), 32'd0);
    check("rst_afull",    32'(bus.wr_almost_full), 32'd0);
    tick(2);
    check("rst_hold_level", 32'(bus.wr_level), 32'd0);
    @(negedge clk);
    reset      = 1'b0;
    bus.wr_req = 1'b0;
    tick(1);

    // Full: write bin 8 (gray 1100), read 0
    bus.wr_gcode_ptr = 4'b1100;
    tick(2);
    check("full_set",    32'(bus.wr_full), 32'd1);
    check("full_level",  32'(bus.wr_level), 32'd8);
    check("full_afull",  32'(bus.wr_almost_full), 32'd1);
    check("full_noreq_incr", 32'(bus.wr_incr), 32'd0);
    bus.wr_req = 1'b1;
    #1;
    check("full_req_incr", 32'(bus.wr_incr), 32'd0);
    check("ovf_before_edge", 32'(bus.wr_overflow), 32'd0);
    tick(1);
    check("ovf_set", 32'(bus.wr_overflow), 32'd1);
    bus.wr_req = 1'b0;

    // Read step 0 -> 1 clears full after exactly two edges
    bus.rd_gcode_ptr_async = 4'b0001;
    tick(1);
    check("rdstep_edge1_full", 32'(bus.wr_full), 32'd1);
    tick(1);
    check("rdstep_edge2_full", 32'(bus.wr_full), 32'd0);
    check("rdstep_edge2_level", 32'(bus.wr_level), 32'd8);
    tick(1);
    check("rdstep_level", 32'(bus.wr_level), 32'd7);
    check("rdstep_afull", 32'(bus.wr_almost_full), 32'd1);
    check("rdstep_ovf_sticky", 32'(bus.wr_overflow), 32'd1);

    // Wrap: write bin 3, read bin 11 -> full
    bus.wr_gcode_ptr       = 4'b0010;
    bus.rd_gcode_ptr_async = 4'b1110;
    tick(3);
    check("wrap_full",  32'(bus.wr_full), 32'd1);
    check("wrap_level", 32'(bus.wr_level), 32'd8);
    // Read bin 12 (gray 1010)
    bus.rd_gcode_ptr_async = 4'b1010;
    tick(3);
    check("wrap_unfull",  32'(bus.wr_full), 32'd0);
    check("wrap_level7",  32'(bus.wr_level), 32'd7);
    bus.wr_req = 1'b1;
    #1;
    check("wrap_incr", 32'(bus.wr_incr), 32'd1);
    bus.wr_req = 1'b0;

    // Threshold: occupancy 5 then 6
    bus.rd_gcode_ptr_async = 4'b0000;
    bus.wr_gcode_ptr       = 4'b0111;
    tick(3);
    check("thr5_level", 32'(bus.wr_level), 32'd5);
    check("thr5_afull", 32'(bus.wr_almost_full), 32'd0);
    bus.wr_gcode_ptr = 4'b0101;
    #1;
    check("thr6_pre_afull", 32'(bus.wr_almost_full), 32'd0);
    tick(1);
    check("thr6_level", 32'(bus.wr_level), 32'd6);
    check("thr6_afull", 32'(bus.wr_almost_full), 32'd1);

    // Async reset between edges while full with overflow set
    bus.wr_gcode_ptr = 4'b1100;
    bus.wr_req       = 1'b1;
    tick(2);
    bus.wr_req = 1'b0;
    check("pre_rst_level", 32'(bus.wr_level), 32'd8);
    check("pre_rst_ovf",   32'(bus.wr_overflow), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_level", 32'(bus.wr_level), 32'd0);
    check("async_rst_ovf",   32'(bus.wr_overflow), 32'd0);
    check("async_rst_afull", 32'(bus.wr_almost_full), 32'd0);
    bus.wr_gcode_ptr = 4'b0000;
    bus.wr_req       = 1'b1;
    #1;
    check("async_rst_full", 32'(bus.wr_full), 32'd0);
    check("async_rst_incr", 32'(bus.wr_incr), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    tick(2);
    check("post_rst_ovf", 32'(bus.wr_overflow), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/async_fifo_wr_status.md
ASYNC_FIFO_WR_STATUS -- requirements
Module: async_fifo_wr_status

Interface
REQ-001 Parameter COUNTER_BITS, default 4, SHALL be the gray pointer width; FIFO depth DEPTH = 2^(COUNTER_BITS-1).
REQ-002 Parameter SYNC_STAGES, default 2, SHALL be the synchronizer flop count; values below 2 SHALL be a parameter check error.
REQ-003 Parameter AFULL_THRESH, default 6, SHALL be the almost-full occupancy level; legal range 1..DEPTH, enforced by a parameter check.
REQ-004 Port `clk`, input, 1 bit, SHALL be the write-domain clock; all flops are on its rising edge.
REQ-005 Port `reset`, input, 1 bit, SHALL be the reset: asynchronous and active-high.
REQ-006 Port `rd_gcode_ptr_async`, input, COUNTER_BITS bits, SHALL be the read-domain registered gray pointer, asynchronous to `clk`.
REQ-007 Port `wr_gcode_ptr`, input, COUNTER_BITS bits, SHALL be the local registered write gray pointer.
REQ-008 Port `wr_req`, input, 1 bit, SHALL be the write request from the producer.
REQ-009 Port `wr_incr`, output, 1 bit, SHALL be the write-accept strobe driving the write pointer counter's increment.
REQ-010 Port `wr_full`, output, 1 bit, SHALL be the FIFO full flag.
REQ-011 Port `wr_almost_full`, output, 1 bit, SHALL be the registered almost-full flag.
REQ-012 Port `wr_level`, output, COUNTER_BITS bits, SHALL be the registered occupancy, range 0..DEPTH.
REQ-013 Port `wr_overflow`, output, 1 bit, SHALL be a sticky error flag for a write attempted while full.

Function
REQ-014 `rd_gcode_ptr_async` SHALL enter the design only through a SYNC_STAGES-deep flop chain (rd_sync); no other logic SHALL sample it.
REQ-015 rd_sync SHALL be converted gray-to-binary combinationally: bin[MSB] = g[MSB]; bin[i] = bin[i+1] XOR g[i].
REQ-016 `wr_gcode_ptr` SHALL be converted gray-to-binary the same way; it is same-domain and SHALL NOT be synchronized.
REQ-017 `wr_full` SHALL be combinational from registered sources: 1 iff wr_gcode_ptr == {~rd_sync[MSB:MSB-1], rd_sync[MSB-2:0]}.
REQ-018 `wr_incr` SHALL equal `wr_req` AND NOT `wr_full`, combinationally, with zero latency.
REQ-019 A read-pointer change at the block input SHALL be reflected in `wr_full` after exactly SYNC_STAGES rising edges of `clk`, given setup is met.
REQ-020 occupancy SHALL be (wr_bin - rd_bin) modulo 2^COUNTER_BITS, with rollover intentional.
REQ-021 `wr_level` SHALL be registered with this occupancy each cycle, one cycle after REQ-020.
REQ-022 `wr_almost_full` SHALL be registered as (occupancy >= AFULL_THRESH), with the same timing as `wr_level`.
REQ-023 `wr_overflow` SHALL set on the cycle after any edge sampling `wr_req`=1 with `wr_full`=1, and SHALL hold until reset.
REQ-024 Wrap-around SHALL be handled solely by the MSB/second-MSB gray comparison; no extra wrap state is permitted.
REQ-025 A simultaneous `wr_req` and full-clearing read SHALL be decided on the currently synchronized value: no accept until rd_sync updates.
REQ-026 Optimistic full deassertion SHALL be impossible, since the synchronized read pointer only lags the true read pointer.

Reset
REQ-027 While `reset` is 1, all rd_sync flops, `wr_level`, `wr_almost_full` and `wr_overflow` SHALL be 0, asynchronously and independent of `clk`.
REQ-028 With both pointers 0 in reset, `wr_full` SHALL be 0 and `wr_incr` SHALL follow `wr_req`.
REQ-029 Reset asserted mid-operation SHALL clear the state within the same cycle, with no dependency on a clock edge.
REQ-030 Release of `reset` SHALL be synchronous-deassert safe, i.e. externally synchronized to `clk`.

Verification (COUNTER_BITS=4, DEPTH=8, SYNC_STAGES=2, AFULL_THRESH=6)
REQ-031 Reset, both pointers 0, `wr_req`=1 -> `wr_full`=0, `wr_incr`=1, `wr_level`=0, `wr_overflow`=0.
REQ-032 `wr_gcode_ptr`=4'b1100 (bin 8), read pointer 0 held 2 cycles -> `wr_full`=1, `wr_level`=8, `wr_almost_full`=1; then `wr_req`=1 -> `wr_incr`=0 and `wr_overflow`=1 on the next cycle.
REQ-033 While full, read pointer steps 4'b0000->4'b0001 -> `wr_full` drops exactly 2 `clk` edges later and `wr_level`=7 one cycle after that; `wr_overflow` stays 1.
REQ-034 Wrap: write pointer bin 3 (gray 0010), read pointer bin 11 (gray 1110) -> `wr_full`=1, `wr_level`=8; read pointer bin 12 -> `wr_full`=0, `wr_level`=7.
REQ-035 Threshold: occupancy 5 -> `wr_almost_full`=0; occupancy 6 -> `wr_almost_full`=1 one cycle later.
REQ-036 `reset` pulsed between `clk` edges with `wr_overflow`=1 and `wr_level`=8 -> both read 0 immediately, before the next edge.
